barrel_shifter_pipe: RTL



---
 rtl/barrel_shifter_pipe.sv | 91 +++++++++
 1 files changed

// File: rtl/barrel_shifter_pipe.sv
// Pipelined WIDTH-bit barrel shifter: rotate right/left, logical right, arithmetic right.
// Latency: SW = log2(WIDTH) cycles, one shift level per register stage, 1 beat/cycle.
// Backpressure: global stall; all stages hold while out_valid & ~out_ready, in_ready = advance.
module barrel_shifter_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_zero
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] M_ROR = 2'b00;
    localparam logic [1:0] M_ROL = 2'b01;
    localparam logic [1:0] M_LSR = 2'b10;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [SW-1:0]    shamt;
        logic [1:0]       mode;
        logic             sign;
    } stg_t;

    logic advance;
    logic zero_q;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int N = 1 << k;

        stg_t src, res, q;
        logic src_vld, vld;

        if (k == 0) begin : g_head
            assign src     = '{dat: in_data, shamt: in_shamt, mode: in_mode, sign: in_data[WIDTH-1]};
            assign src_vld = in_valid & advance;
        end else begin : g_link
            assign src     = g_stage[k-1].q;
            assign src_vld = g_stage[k-1].vld;
        end

        always_comb begin
            res = src;
            if (src.shamt[k]) begin
                case (src.mode)
                    M_ROR:   res.dat = (src.dat >> N) | (src.dat << (WIDTH - N));
                    M_ROL:   res.dat = (src.dat << N) | (src.dat >> (WIDTH - N));
                    M_LSR:   res.dat = src.dat >> N;
                    // sign is the original operand MSB, not this stage's input MSB
                    default: res.dat = (src.dat >> N) | (src.sign ? ~({WIDTH{1'b1}} >> N) : '0);
                endcase
            end
        end

        // bubbles load zero payload so nothing undefined reaches out_data
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= 1'b0;
                q   <= '0;
            end else if (advance) begin
                vld <= src_vld;
                q   <= src_vld ? res : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (advance) begin
            zero_q <= g_stage[SW-1].src_vld & (g_stage[SW-1].res.dat == '0);
        end
    end

    logic tail_unused;
    assign tail_unused = ^{g_stage[SW-1].q.shamt, g_stage[SW-1].q.mode, g_stage[SW-1].q.sign};

    assign out_valid = g_stage[SW-1].vld;
    assign out_data  = g_stage[SW-1].q.dat;
    assign out_zero  = zero_q & out_valid;
endmodule
